// File: rtl/mem_arbiter.sv
// Merges the icache and dcache memory channels onto one external memory port.
// One transaction owns the port until it completes; simultaneous requests alternate.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned DATA_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // icache
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_data_valid,
  output logic                   ic_data_ready,
  input  logic [DATA_BITS-1:0]   ic_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  // dcache
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_data_valid,
  output logic                   dc_data_ready,
  input  logic [DATA_BITS-1:0]   dc_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  // memory
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   stray_resp
);

  localparam int unsigned CntBits = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWdata, StResp} state_e;

  state_e               state_q;
  logic                 owner_q;       // 0 = icache, 1 = dcache
  logic                 last_grant_q;
  logic [CntBits-1:0]   beat_cnt_q;
  logic                 stray_q;

  logic                   grant;
  logic                   own_req_valid;
  logic                   own_req_rw;
  logic [ADDR_BITS-1:0]   own_req_addr;
  logic                   own_data_valid;
  logic [DATA_BITS-1:0]   own_data_bits;
  logic [DATA_BITS/8-1:0] own_data_mask;
  logic                   last_beat;

  always_comb begin
    own_req_valid  = owner_q ? dc_req_valid  : ic_req_valid;
    own_req_rw     = owner_q ? dc_req_rw     : ic_req_rw;
    own_req_addr   = owner_q ? dc_req_addr   : ic_req_addr;
    own_data_valid = owner_q ? dc_data_valid : ic_data_valid;
    own_data_bits  = owner_q ? dc_data_bits  : ic_data_bits;
    own_data_mask  = owner_q ? dc_data_mask  : ic_data_mask;
    // On a tie the cache that did not win last time gets the port.
    grant          = (ic_req_valid && dc_req_valid) ? ~last_grant_q : dc_req_valid;
    last_beat      = (beat_cnt_q == CntBits'(DATA_BEATS - 1));
  end

  always_comb begin
    mem_req_valid      = (state_q == StReq) && own_req_valid;
    mem_req_addr       = own_req_addr;
    mem_req_rw         = own_req_rw;
    ic_req_ready       = (state_q == StReq) && !owner_q && mem_req_ready;
    dc_req_ready       = (state_q == StReq) &&  owner_q && mem_req_ready;

    mem_req_data_valid = (state_q == StWdata) && own_data_valid;
    mem_req_data_bits  = own_data_bits;
    mem_req_data_mask  = own_data_mask;
    ic_data_ready      = (state_q == StWdata) && !owner_q && mem_req_data_ready;
    dc_data_ready      = (state_q == StWdata) &&  owner_q && mem_req_data_ready;

    ic_resp_valid      = (state_q == StResp) && !owner_q && mem_resp_valid;
    dc_resp_valid      = (state_q == StResp) &&  owner_q && mem_resp_valid;
    ic_resp_data       = mem_resp_data;
    dc_resp_data       = mem_resp_data;

    stray_resp         = stray_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      beat_cnt_q   <= '0;
      stray_q      <= 1'b0;
    end else begin
      if (mem_resp_valid && (state_q != StResp)) begin
        stray_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (ic_req_valid || dc_req_valid) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            state_q      <= StReq;
          end
        end
        StReq: begin
          // A withdrawn request releases the port without touching memory.
          if (!own_req_valid) begin
            state_q <= StIdle;
          end else if (mem_req_ready) begin
            if (own_req_rw) begin
              state_q <= StWdata;
            end else begin
              state_q    <= StResp;
              beat_cnt_q <= '0;
            end
          end
        end
        StWdata: begin
          if (own_data_valid && mem_req_data_ready) begin
            state_q <= StIdle;
          end
        end
        StResp: begin
          if (mem_resp_valid) begin
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntBits'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
